// File: rtl/aes_mix_pkg.sv
// Shared GF(2^8) helpers, FSM state type and LANES legality check
// for the MixColumns engine and its per-column lane.
package aes_mix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } mix_state_t;

    // Bit n set means LANES = n is a legal configuration.
    localparam logic [4:0] LEGAL_LANES = 5'b10110;

    function automatic bit lanes_legal(input int l);
        if (l < 1 || l > 4)
            return 1'b0;
        return LEGAL_LANES[l[2:0]];
    endfunction

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gf_mulb(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_muld(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gf_mule(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage

// File: rtl/mix_column_lane.sv
// One-column (Inv)MixColumns, purely combinational.
// Ports: col (byte 0 = [31:24]), inv (1 = inverse), res.
module mix_column_lane
    import aes_mix_pkg::*;
(
    input  logic [31:0] col,
    input  logic        inv,
    output logic [31:0] res
);

    logic [7:0] a [4];

    for (genvar g = 0; g < 4; g++) begin : g_row
        assign a[g] = col[31-8*g -: 8];

        // Row g is the base row rotated right by g.
        assign res[31-8*g -: 8] = inv
            ? (gf_mule(a[g]) ^ gf_mulb(a[(g+1)%4]) ^
               gf_muld(a[(g+2)%4]) ^ gf_mul9(a[(g+3)%4]))
            : (xtime(a[g]) ^ gf_mul3(a[(g+1)%4]) ^
               a[(g+2)%4] ^ a[(g+3)%4]);
    end

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative AES (Inv)MixColumns over a 128-bit state, LANES cols/cycle.
// Ports: clk, rst (sync, high), in_valid/in_ready/inv_i/state_i,
// out_valid/out_ready/state_o. MIXCOL_ADDKEY_EN adds key_i and
// fuses AddRoundKey into the result with no added latency.
module mix_columns_engine
    import aes_mix_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inv_i,
    input  logic [127:0] state_i,
`ifdef MIXCOL_ADDKEY_EN
    input  logic [127:0] key_i,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_o
);

    localparam int NCYC = lanes_legal(LANES) ? 4 / LANES : 1;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

    if (!lanes_legal(LANES)) begin : g_bad_lanes
        $error("mix_columns_engine: LANES must be 1, 2 or 4");
    end

    mix_state_t             st;
    logic [CW-1:0]          col_idx;
    logic [127:0]           blk;
    logic [127:0]           blk_nxt;
    logic [127:0]           res_w;
    logic                   inv_q;
    logic [32*LANES-1:0]    lane_in;
    logic [32*LANES-1:0]    lane_out;

    // Lane l works on column col_idx*LANES + l; results are
    // written back in place so the last cycle sees a full state.
    always_comb begin
        blk_nxt = blk;
        lane_in = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_in[32*l +: 32] =
                blk[127-32*(int'(col_idx)*LANES+l) -: 32];
            blk_nxt[127-32*(int'(col_idx)*LANES+l) -: 32] =
                lane_out[32*l +: 32];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mix_column_lane u_lane (
            .col (lane_in[32*l +: 32]),
            .inv (inv_q),
            .res (lane_out[32*l +: 32])
        );
    end

`ifdef MIXCOL_ADDKEY_EN
    logic [127:0] key_q;

    always_ff @(posedge clk) begin
        if (st == ST_IDLE && in_valid && !rst)
            key_q <= key_i;
    end

    assign res_w = blk_nxt ^ key_q;
`else
    assign res_w = blk_nxt;
`endif

    // Gated with rst so nothing is offered while reset is held.
    assign in_ready = (st == ST_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= ST_IDLE;
            col_idx   <= '0;
            out_valid <= 1'b0;
            state_o   <= '0;
            blk       <= '0;
            inv_q     <= 1'b0;
        end else begin
            unique case (st)
                ST_IDLE: begin
                    if (in_valid) begin
                        blk     <= state_i;
                        inv_q   <= inv_i;
                        col_idx <= '0;
                        st      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    blk <= blk_nxt;
                    if (col_idx == LAST) begin
                        col_idx   <= '0;
                        state_o   <= res_w;
                        out_valid <= 1'b1;
                        st        <= ST_DONE;
                    end else begin
                        col_idx <= col_idx + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        st        <= ST_IDLE;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule
